module_bcd_segment_driver: RTL and testbench
============================================

MODULE_BCD_SEGMENT_DRIVER -- requirements
Module: module_bcd_segment_driver

Interface
REQ-001 Parameter SCAN_PERIOD, default 50000, SHALL set the number of clk_in cycles each digit is lit (1 kHz digit rate at 50 MHz).
REQ-002 Port clk_in, input, 1, SHALL be the single clock; all logic is rising-edge triggered on it.
REQ-003 Port rst_in, input, 1, SHALL be the synchronous, active-high reset.
REQ-004 Port value_in, input, 8, SHALL carry the unsigned binary count from the upstream counter, which runs on a divided clock and is asynchronous to clk_in.
REQ-005 Port bcd_out, output, 12, SHALL hold the converted value: {hundreds, tens, units}, 4 bits each.
REQ-006 Port busy, output, 1, SHALL be high while a conversion is in progress.
REQ-007 Port seg_n, output, 7, SHALL drive active-low segments ordered {g,f,e,d,c,b,a}.
REQ-008 Port an_n, output, 3, SHALL drive active-low digit enables: bit0 units, bit1 tens, bit2 hundreds.

Function
REQ-009 value_in SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-010 The converter FSM SHALL have states IDLE, CONV, LOAD; reset state IDLE.
REQ-011 In IDLE, if s2 differs from the last converted value, the FSM SHALL capture s2 into the shift register and into last_value, clear the iteration count, set busy, and go to CONV.
REQ-012 In CONV, each cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one; after exactly 8 iterations the FSM SHALL go to LOAD.
REQ-013 In LOAD, the FSM SHALL write the result to bcd_out, clear busy, and return to IDLE.
REQ-014 Latency: value_in stable from clock edge N SHALL give busy high from edge N+3 to N+12 (9 cycles) and an updated bcd_out at edge N+12.
REQ-015 Changes on s2 during CONV or LOAD SHALL NOT disturb the running conversion; the FSM SHALL re-evaluate them on its next IDLE cycle.
REQ-016 An unchanged s2 in IDLE SHALL NOT start a conversion.
REQ-017 bcd_out SHALL always satisfy nibble <= 9 and hundreds <= 2; the range is 0..255.
REQ-018 The scan counter SHALL count 0..SCAN_PERIOD-1 and wrap; on wrap the digit index SHALL advance 0->1->2->0.
REQ-019 an_n SHALL be registered: index 0 -> 3'b110, index 1 -> 3'b101, index 2 -> 3'b011; exactly one digit is active.
REQ-020 seg_n SHALL be registered from the bcd_out nibble selected by the digit index, updated in the same cycle as an_n.
REQ-021 Encoding (seg_n) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code = 1111111.
REQ-022 Leading-zero blanking: a zero hundreds digit SHALL show 1111111; a zero tens digit SHALL show 1111111 only when hundreds is also zero; units SHALL never blank.

Reset
REQ-023 rst_in high at an edge SHALL clear s1, s2, last_value, the shift register, iteration count, bcd_out, busy, scan counter, and digit index, and force FSM=IDLE, an_n=3'b110, seg_n=7'b1000000.
REQ-024 Reset during CONV SHALL abort the conversion with no partial result reaching bcd_out.
REQ-025 After reset, a nonzero value_in SHALL trigger a conversion per REQ-014, because last_value is reset to 0.

Verification
REQ-026 Reset with value_in=0 -> bcd_out=12'h000, busy=0, an_n=3'b110, seg_n=7'b1000000, and no conversion starts.
REQ-027 value_in=255 from edge N -> busy high for edges N+3..N+11, bcd_out=12'h255 at N+12.
REQ-028 SCAN_PERIOD=4, value_in=7 -> an_n cycles 110,101,011 every 4 cycles; seg_n is 1111000 on units and 1111111 on tens and hundreds.
REQ-029 value_in=100 -> bcd_out=12'h100; the tens digit shows 1000000 (not blanked).
REQ-030 value_in 10 then 200 two cycles into CONV -> bcd_out=12'h010 at the first LOAD, then a second conversion gives 12'h200; a sequence 5->6->5 during one conversion gives a final bcd_out=12'h005.
REQ-031 rst_in pulsed during CONV of 255 -> bcd_out stays 12'h000 and busy=0 after the reset edge; the conversion restarts when rst_in deasserts.

Source files
------------

// File: rtl/module_bcd_segment_driver.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed
// 3-digit active-low seven-segment display with leading-zero blanking.
module module_bcd_segment_driver #(
  parameter int SCAN_PERIOD = 50000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  value_in,
  output logic [11:0] bcd_out,
  output logic        busy,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n
);

  localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    s1_q, s1_d;
  logic [7:0]    s2_q, s2_d;
  logic [7:0]    last_q, last_d;
  logic [19:0]   sr_q, sr_d;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [19:0]   adj;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter FSM and double-dabble datapath
  always_comb begin
    state_d = state_q;
    s1_d    = value_in;
    s2_d    = s1_q;
    last_d  = last_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    adj     = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5) begin
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      IDLE: begin
        if (s2_q != last_q) begin
          sr_d    = {12'd0, s2_q};
          last_d  = s2_q;
          iter_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d   = {adj[18:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = sr_q[19:8];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan; an_n and seg_n follow the next digit index
  always_comb begin
    scan_d = scan_q + CW'(1);
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
    nib   = bcd_q[3:0];
    blank = 1'b0;
    an_d  = 3'b110;
    unique case (1'b1)
      (dig_d == 2'd1): begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[7:4] == 4'd0) && (bcd_q[11:8] == 4'd0);
        an_d  = 3'b101;
      end
      (dig_d == 2'd2): begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
        an_d  = 3'b011;
      end
      default: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
        an_d  = 3'b110;
      end
    endcase
    seg_d = blank ? 7'b1111111 : enc7(nib);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      last_q  <= '0;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= '0;
      an_q    <= 3'b110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd_out = bcd_q;
  assign busy    = busy_q;
  assign seg_n   = seg_q;
  assign an_n    = an_q;

endmodule

// File: tb/tb_module_bcd_segment_driver.sv
// Directed bench for module_bcd_segment_driver: latency, conversion
// values, scan rotation, blanking and reset abort.
module tb_module_bcd_segment_driver;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  value_in;
  logic [11:0] bcd_out;
  logic        busy;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  module_bcd_segment_driver #(.SCAN_PERIOD(4)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .value_in(value_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
    k++;
  endtask

  task automatic do_reset;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    k = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b,
                                         input int d);
    if (d == 2) return (b[11:8] == 0) ? 7'b1111111 : enc(b[11:8]);
    if (d == 1) return (b[7:4] == 0 && b[11:8] == 0) ?
                       7'b1111111 : enc(b[7:4]);
    return enc(b[3:0]);
  endfunction

  function automatic logic [2:0] exp_an(input int d);
    if (d == 1) return 3'b101;
    if (d == 2) return 3'b011;
    return 3'b110;
  endfunction

  task automatic chk_disp(input logic [11:0] b);
    int d;
    d = (k / 4) % 3;
    chk("an_n", {29'd0, an_n}, {29'd0, exp_an(d)});
    chk("seg_n", {25'd0, seg_n}, {25'd0, exp_seg(b, d)});
  endtask

  task automatic chk_busy(input string tag, input logic e);
    chk(tag, {31'd0, busy}, {31'd0, e});
  endtask

  task automatic chk_bcd(input string tag, input logic [11:0] e);
    chk(tag, {20'd0, bcd_out}, {20'd0, e});
  endtask

  initial begin
    value_in = 8'd0;
    do_reset();
    chk_bcd("rst_bcd", 12'h000);
    chk_busy("rst_busy", 1'b0);
    chk("rst_an", {29'd0, an_n}, 32'b110);
    chk("rst_seg", {25'd0, seg_n}, 32'b1000000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_busy("idle_busy", 1'b0);
      chk_bcd("idle_bcd", 12'h000);
    end

    // 255: full latency profile
    value_in = 8'd255;
    tick();
    tick();
    chk_busy("lat_n2", 1'b0);
    for (int i = 3; i <= 11; i++) begin
      tick();
      chk_busy("lat_busy", 1'b1);
      chk_bcd("lat_hold", 12'h000);
    end
    tick();
    chk_busy("lat_n12", 1'b0);
    chk_bcd("bcd_255", 12'h255);
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_disp(12'h255);
      tick();
    end

    value_in = 8'd100;
    for (int i = 0; i < 12; i++) tick();
    chk_bcd("bcd_100", 12'h100);
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_disp(12'h100);
      tick();
    end

    // Scan rotation and blanking with a single digit
    do_reset();
    value_in = 8'd7;
    for (int i = 0; i < 12; i++) tick();
    chk_bcd("bcd_7", 12'h007);
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_disp(12'h007);
      tick();
    end

    // Change during CONV is deferred
    value_in = 8'd10;
    for (int i = 0; i < 5; i++) tick();
    value_in = 8'd200;
    for (int i = 0; i < 7; i++) tick();
    chk_bcd("bcd_10", 12'h010);
    chk_busy("after_10", 1'b0);
    tick();
    chk_busy("restart_200", 1'b1);
    for (int i = 0; i < 9; i++) tick();
    chk_bcd("bcd_200", 12'h200);
    chk_busy("done_200", 1'b0);

    // 5 -> 6 -> 5 inside one conversion
    value_in = 8'd5;
    for (int i = 0; i < 5; i++) tick();
    value_in = 8'd6;
    tick();
    tick();
    value_in = 8'd5;
    for (int i = 0; i < 5; i++) tick();
    chk_bcd("bcd_5", 12'h005);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_busy("no_reconv", 1'b0);
    end
    chk_bcd("bcd_5_hold", 12'h005);

    // Reset mid-conversion
    value_in = 8'd255;
    for (int i = 0; i < 5; i++) tick();
    chk_busy("pre_abort", 1'b1);
    do_reset();
    chk_bcd("abort_bcd", 12'h000);
    chk_busy("abort_busy", 1'b0);
    chk("abort_an", {29'd0, an_n}, 32'b110);
    chk("abort_seg", {25'd0, seg_n}, 32'b1000000);
    tick();
    tick();
    chk_busy("re_n2", 1'b0);
    tick();
    chk_busy("re_n3", 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_bcd("re_hold", 12'h000);
    end
    tick();
    chk_bcd("re_255", 12'h255);
    chk_busy("re_done", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
